// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester-side bundle for mem_port_arbiter (port D load/store, port F fetch)
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;

  logic                  f_req;
  logic [ADDR_WIDTH-1:0] f_addr;
  logic                  f_gnt;
  logic                  f_rvalid;
  logic [DATA_WIDTH-1:0] f_rdata;

  modport master (
    output d_req, d_we, d_addr, d_wdata, f_req, f_addr,
    input  d_gnt, d_rvalid, d_rdata, f_gnt, f_rvalid, f_rdata
  );

  modport slave (
    input  d_req, d_we, d_addr, d_wdata, f_req, f_addr,
    output d_gnt, d_rvalid, d_rdata, f_gnt, f_rvalid, f_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for a 1R/1W memory; define MEM_ARB_RR_EN for round-robin read conflicts
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_port_arbiter_if.slave     bus,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  localparam int              CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]   LIMIT = CW'(STARVE_LIMIT);

  logic d_load;
  logic conflict;
  logic d_wins;
  logic d_gnt;
  logic f_gnt;
  logic d_rd_gnt;

  logic [CW-1:0]         starve_cnt_q, starve_cnt_d;
  logic                  rr_last_q, rr_last_d;
  logic                  d_rvalid_q, d_rvalid_d;
  logic                  f_rvalid_q, f_rvalid_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic [DATA_WIDTH-1:0] f_rdata_q, f_rdata_d;

  // Grants are gated by rst_n so nothing reaches the memory while reset is held.
  always_comb begin
    d_load   = bus.d_req & ~bus.d_we;
    conflict = d_load & bus.f_req;
`ifdef MEM_ARB_RR_EN
    d_wins   = rr_last_q;
`else
    d_wins   = (starve_cnt_q != LIMIT);
`endif
    d_gnt    = rst_n & bus.d_req & ~(conflict & ~d_wins);
    f_gnt    = rst_n & bus.f_req & ~(conflict & d_wins);
    d_rd_gnt = d_gnt & ~bus.d_we;
  end

  always_comb begin
    mem_write_en   = d_gnt & bus.d_we;
    mem_write_addr = bus.d_addr;
    mem_data_in    = bus.d_wdata;
    mem_read_addr  = d_rd_gnt ? bus.d_addr : bus.f_addr;
  end

  // rr_last=1 means F won the most recent conflict, so D is next in line.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    rr_last_d    = rr_last_q;
`ifdef MEM_ARB_RR_EN
    starve_cnt_d = '0;
    if (conflict && rst_n) begin
      rr_last_d = f_gnt;
    end
`else
    rr_last_d = 1'b0;
    if (!bus.f_req || f_gnt) begin
      starve_cnt_d = '0;
    end else if (conflict && starve_cnt_q != LIMIT) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
`endif
  end

  always_comb begin
    d_rvalid_d = d_rd_gnt;
    f_rvalid_d = f_gnt;
    d_rdata_d  = d_rd_gnt ? mem_data_out : d_rdata_q;
    f_rdata_d  = f_gnt    ? mem_data_out : f_rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      rr_last_q    <= 1'b0;
      d_rvalid_q   <= 1'b0;
      f_rvalid_q   <= 1'b0;
      d_rdata_q    <= '0;
      f_rdata_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rr_last_q    <= rr_last_d;
      d_rvalid_q   <= d_rvalid_d;
      f_rvalid_q   <= f_rvalid_d;
      d_rdata_q    <= d_rdata_d;
      f_rdata_q    <= f_rdata_d;
    end
  end

  assign bus.d_gnt    = d_gnt;
  assign bus.f_gnt    = f_gnt;
  assign bus.d_rvalid = d_rvalid_q;
  assign bus.f_rvalid = f_rvalid_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.f_rdata  = f_rdata_q;

endmodule
